// File: rtl/fifo_top.sv
// Single-clock show-ahead FIFO with valid/grant handshakes on both sides.
// The storage and pointer logic lives in fifo_core (instance fifo_i); the top
// level only adds the optional parity substitution on the outgoing word.

module fifo_core #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   push_data,
  input  logic                  push_valid,
  input  logic                  pop_grant,
  output logic [DATA_WIDTH:0]   head,
  output logic                  not_full,
  output logic                  not_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    count_write;
  logic [PTR_W-1:0]    count_read;
  logic [CNT_W-1:0]    count_fifo;
  logic                push_fire;
  logic                pop_fire;

  // Pointers wrap explicitly so the depth need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant depends on occupancy alone, so a full FIFO refuses a push even
  // when a pop happens in the same cycle.
  assign not_full  = (count_fifo != CNT_W'(FIFO_DEPTH));
  assign not_empty = (count_fifo != '0);
  assign push_fire = push_valid && not_full;
  assign pop_fire  = pop_grant && not_empty;
  assign head      = mem[count_read];

  // Storage: written at the write pointer, wiped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push_fire) begin
      mem[count_write] <= push_data;
    end
  end

  // Read and write pointers advance on their respective handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_write <= '0;
      count_read  <= '0;
    end else begin
      if (push_fire) count_write <= next_ptr(count_write);
      if (pop_fire)  count_read  <= next_ptr(count_read);
    end
  end

  // Occupancy tracks the net of pushes and pops in each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_fifo <= '0;
    end else begin
      case ({push_fire, pop_fire})
        2'b10:   count_fifo <= count_fifo + 1'b1;
        2'b01:   count_fifo <= count_fifo - 1'b1;
        default: count_fifo <= count_fifo;
      endcase
    end
  end

endmodule

module fifo_top #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_WIDTH:0] push_data_i,
  input  logic                push_valid_i,
  output logic                push_grant_o,
  input  logic                pop_grant_i,
  output logic [DATA_WIDTH:0] pop_data_o,
  output logic                pop_valid_o
);

  logic [DATA_WIDTH:0] head;

  // rst_n is active-high despite its name.
  fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) fifo_i (
    .clk        (clk),
    .rst        (rst_n),
    .push_data  (push_data_i),
    .push_valid (push_valid_i),
    .pop_grant  (pop_grant_i),
    .head       (head),
    .not_full   (push_grant_o),
    .not_empty  (pop_valid_o)
  );

  // Either pass the top bit through or replace it with parity of the payload.
  function automatic logic [DATA_WIDTH:0] apply_parity(input logic [DATA_WIDTH:0] word);
    logic [DATA_WIDTH:0] res;
    res = word;
    if (PARITY_BIT != 0) res[DATA_WIDTH] = (^word[DATA_WIDTH-1:0]) ^ (EVEN_ODD != 0);
    return res;
  endfunction

  assign pop_data_o = apply_parity(head);

endmodule

// File: tb/tb_fifo_top.sv
// Bench for fifo_top: a queue-based reference model predicts handshakes,
// head data and pointer/occupancy values for a depth-4 FIFO; two extra
// instances exercise even and odd parity substitution.

module tb_fifo_top;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [DW:0]   push_data;
  logic          push_valid;
  logic          push_grant;
  logic          pop_grant;
  logic [DW:0]   pop_data;
  logic          pop_valid;

  logic [DW:0]   p_data;
  logic          p_valid;
  logic          p_grant;
  logic [DW:0]   pe_data, po_data;
  logic          pe_pgrant, po_pgrant, pe_valid, po_valid;

  int pass_cnt = 0;
  int total    = 0;

  logic [DW:0] q [$];
  int wr_total = 0;
  int rd_total = 0;

  fifo_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .EVEN_ODD(0), .PARITY_BIT(0)) dut (
    .clk(clk), .rst_n(rst), .push_data_i(push_data), .push_valid_i(push_valid),
    .push_grant_o(push_grant), .pop_grant_i(pop_grant), .pop_data_o(pop_data),
    .pop_valid_o(pop_valid));

  fifo_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .EVEN_ODD(0), .PARITY_BIT(1)) dut_pe (
    .clk(clk), .rst_n(rst), .push_data_i(p_data), .push_valid_i(p_valid),
    .push_grant_o(pe_pgrant), .pop_grant_i(p_grant), .pop_data_o(pe_data),
    .pop_valid_o(pe_valid));

  fifo_top #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .EVEN_ODD(1), .PARITY_BIT(1)) dut_po (
    .clk(clk), .rst_n(rst), .push_data_i(p_data), .push_valid_i(p_valid),
    .push_grant_o(po_pgrant), .pop_grant_i(p_grant), .pop_data_o(po_data),
    .pop_valid_o(po_valid));

  // First rising edge at t=12, leaving a clock-free window for the reset check.
  initial begin
    clk = 0;
    #7;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW:0] rand_word();
    logic [DW:0] w;
    w = {1'($urandom_range(0, 1)), 32'($urandom)};
    return w;
  endfunction

  // One clock edge on the main DUT; the model is updated from the pre-edge state.
  task automatic drive_edge(input logic pv, input logic pg, input logic [DW:0] d);
    bit pf, qf;
    push_valid = pv;
    pop_grant  = pg;
    push_data  = d;
    pf = pv && (q.size() < DEPTH);
    qf = pg && (q.size() > 0);
    @(posedge clk);
    if (qf) begin void'(q.pop_front()); rd_total++; end
    if (pf) begin q.push_back(d); wr_total++; end
    #1;
    push_valid = 0;
    pop_grant  = 0;
  endtask

  task automatic model_clear();
    q.delete();
    wr_total = 0;
    rd_total = 0;
  endtask

  task automatic test_reset();
    rst = 0; push_valid = 0; pop_grant = 0; push_data = '0;
    p_valid = 0; p_grant = 0; p_data = '0;
    #1 rst = 1;
    #5;
    total++; if (dut.fifo_i.count_read !== 2'd0) $display("FAIL rst_count_read got %0d exp 0", dut.fifo_i.count_read); else pass_cnt++;
    total++; if (dut.fifo_i.count_write !== 2'd0) $display("FAIL rst_count_write got %0d exp 0", dut.fifo_i.count_write); else pass_cnt++;
    total++; if (dut.fifo_i.count_fifo !== 3'd0) $display("FAIL rst_count_fifo got %0d exp 0", dut.fifo_i.count_fifo); else pass_cnt++;
    total++; if (push_grant !== 1'b1) $display("FAIL rst_push_grant got %0b exp 1", push_grant); else pass_cnt++;
    total++; if (pop_valid !== 1'b0) $display("FAIL rst_pop_valid got %0b exp 0", pop_valid); else pass_cnt++;
    total++; if (pop_data !== 33'h0) $display("FAIL rst_pop_data got %h exp 0", pop_data); else pass_cnt++;
    total++; if (pe_data !== 33'h0) $display("FAIL rst_even_data got %h exp 0", pe_data); else pass_cnt++;
    total++; if (po_data !== 33'h1_00000000) $display("FAIL rst_odd_data got %h exp 100000000", po_data); else pass_cnt++;
    #2 rst = 0;
    model_clear();
  endtask

  task automatic test_overflow();
    logic [DW:0] d;
    for (int i = 0; i < 6; i++) begin
      d = rand_word();
      total++; if (push_grant !== (q.size() < DEPTH)) $display("FAIL ovf_grant push %0d got %0b exp %0b", i, push_grant, q.size() < DEPTH); else pass_cnt++;
      drive_edge(1, 0, d);
      total++; if (dut.fifo_i.count_write !== 2'(wr_total % DEPTH)) $display("FAIL ovf_count_write push %0d got %0d exp %0d", i, dut.fifo_i.count_write, wr_total % DEPTH); else pass_cnt++;
    end
    total++; if (dut.fifo_i.count_fifo !== 3'd4) $display("FAIL ovf_count_fifo got %0d exp 4", dut.fifo_i.count_fifo); else pass_cnt++;
    total++; if (dut.fifo_i.count_read !== 2'd0) $display("FAIL ovf_count_read got %0d exp 0", dut.fifo_i.count_read); else pass_cnt++;
    total++; if (push_grant !== 1'b0) $display("FAIL ovf_grant_full got %0b exp 0", push_grant); else pass_cnt++;
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 6; i++) begin
      total++; if (pop_valid !== (q.size() > 0)) $display("FAIL udf_valid pop %0d got %0b exp %0b", i, pop_valid, q.size() > 0); else pass_cnt++;
      if (q.size() > 0) begin
        total++; if (pop_data !== q[0]) $display("FAIL udf_data pop %0d got %h exp %h", i, pop_data, q[0]); else pass_cnt++;
      end
      drive_edge(0, 1, '0);
      total++; if (dut.fifo_i.count_read !== 2'(rd_total % DEPTH)) $display("FAIL udf_count_read pop %0d got %0d exp %0d", i, dut.fifo_i.count_read, rd_total % DEPTH); else pass_cnt++;
    end
    total++; if (dut.fifo_i.count_fifo !== 3'd0) $display("FAIL udf_count_fifo got %0d exp 0", dut.fifo_i.count_fifo); else pass_cnt++;
    total++; if (pop_valid !== 1'b0) $display("FAIL udf_valid_empty got %0b exp 0", pop_valid); else pass_cnt++;
  endtask

  task automatic test_concurrent();
    for (int i = 0; i < 30; i++) begin
      if (q.size() > 0) begin
        total++; if (pop_data !== q[0]) $display("FAIL conc_data cycle %0d got %h exp %h", i, pop_data, q[0]); else pass_cnt++;
      end
      drive_edge(1, 1, rand_word());
      total++; if (dut.fifo_i.count_fifo !== 3'(q.size()) || dut.fifo_i.count_fifo > 3'd1)
        $display("FAIL conc_count_fifo cycle %0d got %0d exp %0d", i, dut.fifo_i.count_fifo, q.size()); else pass_cnt++;
    end
    drive_edge(0, 1, '0);
    total++; if (pop_valid !== 1'b0) $display("FAIL conc_drain_valid got %0b exp 0", pop_valid); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    drive_edge(1, 0, rand_word());
    drive_edge(1, 0, rand_word());
    #2 rst = 1;
    #1;
    total++; if (pop_valid !== 1'b0) $display("FAIL midrst_valid got %0b exp 0", pop_valid); else pass_cnt++;
    total++; if (dut.fifo_i.count_fifo !== 3'd0) $display("FAIL midrst_count_fifo got %0d exp 0", dut.fifo_i.count_fifo); else pass_cnt++;
    total++; if (dut.fifo_i.count_write !== 2'd0) $display("FAIL midrst_count_write got %0d exp 0", dut.fifo_i.count_write); else pass_cnt++;
    total++; if (pop_data !== 33'h0) $display("FAIL midrst_data got %h exp 0", pop_data); else pass_cnt++;
    rst = 0;
    model_clear();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive_edge(1, 0, rand_word());
    for (int i = 0; i < 3; i++) drive_edge(0, 1, '0);
    total++; if (dut.fifo_i.count_write !== 2'd3 || dut.fifo_i.count_read !== 2'd3)
      $display("FAIL wrap_ptrs_pre got w=%0d r=%0d exp w=3 r=3", dut.fifo_i.count_write, dut.fifo_i.count_read); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive_edge(1, 0, rand_word());
      total++; if (dut.fifo_i.count_write !== 2'(wr_total % DEPTH)) $display("FAIL wrap_count_write push %0d got %0d exp %0d", i, dut.fifo_i.count_write, wr_total % DEPTH); else pass_cnt++;
    end
    total++; if (push_grant !== 1'b0) $display("FAIL wrap_grant_full got %0b exp 0", push_grant); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++; if (pop_data !== q[0]) $display("FAIL wrap_data pop %0d got %h exp %h", i, pop_data, q[0]); else pass_cnt++;
      drive_edge(0, 1, '0);
      if (i == 0) begin
        total++; if (push_grant !== 1'b1) $display("FAIL wrap_grant_reopen got %0b exp 1", push_grant); else pass_cnt++;
      end
    end
    total++; if (dut.fifo_i.count_read !== 2'd3) $display("FAIL wrap_count_read got %0d exp 3", dut.fifo_i.count_read); else pass_cnt++;
  endtask

  task automatic test_random();
    logic pv, pg;
    for (int i = 0; i < 300; i++) begin
      pv = 1'($urandom_range(0, 1));
      pg = 1'($urandom_range(0, 1));
      total++; if (push_grant !== (q.size() < DEPTH) || pop_valid !== (q.size() > 0))
        $display("FAIL rand_flags cycle %0d got g=%0b v=%0b exp g=%0b v=%0b", i, push_grant, pop_valid, q.size() < DEPTH, q.size() > 0); else pass_cnt++;
      if (q.size() > 0) begin
        total++; if (pop_data !== q[0]) $display("FAIL rand_data cycle %0d got %h exp %h", i, pop_data, q[0]); else pass_cnt++;
      end
      drive_edge(pv, pg, rand_word());
      total++; if (dut.fifo_i.count_fifo !== 3'(q.size())) $display("FAIL rand_count_fifo cycle %0d got %0d exp %0d", i, dut.fifo_i.count_fifo, q.size()); else pass_cnt++;
    end
  endtask

  task automatic test_parity();
    logic [DW:0] w;
    logic        ones_odd;
    for (int i = 0; i < 9; i++) begin
      w = (i == 0) ? 33'h0_00000007 : rand_word();
      ones_odd = 1'($countones(w[DW-1:0]) % 2);
      p_data = w; p_valid = 1;
      @(posedge clk); #1;
      p_valid = 0;
      total++; if (pe_valid !== 1'b1 || po_valid !== 1'b1) $display("FAIL par_valid word %0d got e=%0b o=%0b exp 1", i, pe_valid, po_valid); else pass_cnt++;
      total++; if (pe_data[DW] !== ones_odd) $display("FAIL par_even_bit word %0d got %0b exp %0b", i, pe_data[DW], ones_odd); else pass_cnt++;
      total++; if (po_data[DW] !== !ones_odd) $display("FAIL par_odd_bit word %0d got %0b exp %0b", i, po_data[DW], !ones_odd); else pass_cnt++;
      total++; if (pe_data[DW-1:0] !== w[DW-1:0] || po_data[DW-1:0] !== w[DW-1:0])
        $display("FAIL par_payload word %0d got e=%h o=%h exp %h", i, pe_data[DW-1:0], po_data[DW-1:0], w[DW-1:0]); else pass_cnt++;
      p_grant = 1;
      @(posedge clk); #1;
      p_grant = 0;
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_underflow();
    test_concurrent();
    test_mid_reset();
    test_wrap();
    test_random();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
